// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths, control bit indices and state encoding for the MEM/WB register
package mem_wb_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 2;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  // Encoding doubles as the entry count reported on the count port.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_payload_slot.sv
// rtl/wb_payload_slot.sv - one writeback payload register {alu, mem, rd, ctrl} with load and clear
// Ports: clk/rst (sync, active-high); clear zeroes every field; load captures d_*;
//        clear_ctrl zeroes only ctrl so a bubble never carries RegWrite; q_* is the held payload.
module wb_payload_slot #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [DATA_W-1:0] d_mem,
  input  logic [RD_W-1:0]   d_rd,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_alu,
  output logic [DATA_W-1:0] q_mem,
  output logic [RD_W-1:0]   q_rd,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q_alu  <= '0;
      q_mem  <= '0;
      q_rd   <= '0;
      q_ctrl <= '0;
    end else if (load) begin
      q_alu  <= d_alu;
      q_mem  <= d_mem;
      q_rd   <= d_rd;
      q_ctrl <= d_ctrl;
    end else if (clear_ctrl) begin
      q_ctrl <= '0;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// rtl/mem_wb_skid_reg.sv - MEM/WB pipeline register with valid/ready flow control and optional skid slot
// Ports: clk, rst (sync, active-high), flush drops all held entries;
//        in_valid/in_ready/in_* from MEM; out_valid/out_ready/out_* to WB; count = entries held.
module mem_wb_skid_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W  = mem_wb_pkg::DATA_W,
  parameter int RD_W    = mem_wb_pkg::RD_W,
  parameter int CTRL_W  = mem_wb_pkg::CTRL_W,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  wb_state_t st, nxt;
  logic      in_ready_q;
  logic      accept, drain;
  logic      m_load, m_from_s, m_clr_ctrl, s_load;

  logic [DATA_W-1:0] m_alu, m_mem, s_alu, s_mem, md_alu, md_mem;
  logic [RD_W-1:0]   m_rd, s_rd, md_rd;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, md_ctrl;

  assign out_valid = (st != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign count     = st;

  // With the skid slot in_ready comes from a flop; without it WB backpressure
  // reaches MEM combinationally.
  assign in_ready = (SKID_EN != 0) ? in_ready_q : (!out_valid | out_ready);

  always_comb begin
    nxt        = st;
    m_load     = 1'b0;
    m_from_s   = 1'b0;
    m_clr_ctrl = 1'b0;
    s_load     = 1'b0;
    if (flush) begin
      nxt = ST_EMPTY;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (accept) begin
            m_load = 1'b1;
            nxt    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            m_load = 1'b1;
          end else if (accept && (SKID_EN != 0)) begin
            s_load = 1'b1;
            nxt    = ST_FULL;
          end else if (drain) begin
            m_clr_ctrl = 1'b1;
            nxt        = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            nxt      = ST_ONE;
          end
        end
        default: nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      st         <= nxt;
      in_ready_q <= (nxt != ST_FULL);
    end
  end

  assign md_alu  = m_from_s ? s_alu  : in_alu;
  assign md_mem  = m_from_s ? s_mem  : in_mem;
  assign md_rd   = m_from_s ? s_rd   : in_rd;
  assign md_ctrl = m_from_s ? s_ctrl : in_ctrl;

  wb_payload_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_slot_m (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .load       (m_load),
    .clear_ctrl (m_clr_ctrl),
    .d_alu      (md_alu),
    .d_mem      (md_mem),
    .d_rd       (md_rd),
    .d_ctrl     (md_ctrl),
    .q_alu      (m_alu),
    .q_mem      (m_mem),
    .q_rd       (m_rd),
    .q_ctrl     (m_ctrl)
  );

  // Never loaded when SKID_EN=0, so it reduces to constant zero.
  wb_payload_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_slot_s (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .load       (s_load),
    .clear_ctrl (1'b0),
    .d_alu      (in_alu),
    .d_mem      (in_mem),
    .d_rd       (in_rd),
    .d_ctrl     (in_ctrl),
    .q_alu      (s_alu),
    .q_mem      (s_mem),
    .q_rd       (s_rd),
    .q_ctrl     (s_ctrl)
  );

  assign out_alu  = m_alu;
  assign out_mem  = m_mem;
  assign out_rd   = m_rd;
  assign out_ctrl = out_valid ? m_ctrl : '0;

endmodule
